// File: rtl/exec_pkg.sv
// exec_pkg: op codes, FSM states and word helpers shared by the execution unit
package exec_pkg;
    localparam int WORD_W = 32;
    typedef enum logic [4:0] {
        OP_ADD = 5'd0, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL = 5'd16, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;
    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction
endpackage

// File: rtl/exec_if.sv
// exec_if: operand/result valid-ready bundle between a producer/consumer and exec_unit
interface exec_if #(parameter int XLEN = 64) ();
    logic            in_valid, in_ready, work_on_word, out_valid, out_ready, zero;
    logic [4:0]      op;
    logic [XLEN-1:0] a, b, res;
    modport master (output in_valid, a, b, op, work_on_word, out_ready,
                    input in_ready, out_valid, res, zero);
    modport slave (input in_valid, a, b, op, work_on_word, out_ready,
                   output in_ready, out_valid, res, zero);
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 shift-add multiplier / restoring divider with sign fixup and special-case detection
module muldiv_iter import exec_pkg::*; #(parameter int XLEN = 64) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill_i,
    input  logic            start_i,
    input  op_e             op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic            special_o,
    output logic [XLEN-1:0] res_o,
    output logic [XLEN-1:0] special_res_o
);
    localparam logic [XLEN-1:0] ONES = '1;
    logic              w, is_div, a_sgn, b_sgn, neg_a, neg_b, bz, ovf;
    logic [XLEN-1:0]   ax, bx, mag_a, mag_b, spec_raw;
    logic              busy_q, w_q, neg_q, nega_q, spec_q;
    logic [5:0]        cnt_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   x_q, x_d, spec_res_q, q_s, r_s, raw;
    logic [2*XLEN-1:0] acc_q, acc_d, y_q, y_d, p_s;
    logic [XLEN:0]     trial, diff;
    assign w = word_i && XLEN == 64;
    assign is_div = op_i[2];
    assign a_sgn = op_i inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign b_sgn = op_i inside {OP_MULH, OP_DIV, OP_REM};
    assign ax = w ? XLEN'({{32{a_sgn & a_i[31]}}, a_i[31:0]}) : a_i;
    assign bx = w ? XLEN'({{32{b_sgn & b_i[31]}}, b_i[31:0]}) : b_i;
    assign neg_a = a_sgn & ax[XLEN-1];
    assign neg_b = b_sgn & bx[XLEN-1];
    assign mag_a = neg_a ? -ax : ax;
    assign mag_b = neg_b ? -bx : bx;
    assign bz = bx == '0;
    assign ovf = op_i inside {OP_DIV, OP_REM} && ax == (ONES << (w ? WORD_W - 1 : XLEN - 1)) && bx == ONES;
    assign special_o = is_div && (bz || ovf);
    // op_i[1] separates REM/REMU from DIV/DIVU
    assign spec_raw = bz ? (op_i[1] ? ax : ONES) : (op_i[1] ? '0 : ax);
    assign special_res_o = w ? XLEN'(sext32(spec_raw[31:0])) : spec_raw;
    assign done_o = busy_q && cnt_q == (w_q ? 6'(WORD_W - 1) : 6'(XLEN - 1));
    assign res_o = spec_q ? spec_res_q : (w_q ? XLEN'(sext32(raw[31:0])) : raw);
    // the final step is folded into the result path so done and result land in the same cycle
    always_comb begin
        trial = {acc_q[XLEN-1:0], x_q[XLEN-1]};
        diff = trial - {1'b0, y_q[XLEN-1:0]};
        acc_d = op_q[2] ? {{XLEN{1'b0}}, diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0]} : acc_q + (x_q[0] ? y_q : '0);
        x_d = op_q[2] ? {x_q[XLEN-2:0], !diff[XLEN]} : x_q >> 1;
        y_d = op_q[2] ? y_q : y_q << 1;
        p_s = neg_q ? -acc_d : acc_d;
        q_s = neg_q ? -x_d : x_d;
        r_s = nega_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        raw = op_q[2] ? (op_q[1] ? r_s : q_s)
                      : (op_q[1:0] == 2'd0 ? p_s[XLEN-1:0] : (w_q ? XLEN'(p_s[63:32]) : p_s[2*XLEN-1:XLEN]));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q <= '0;
            op_q <= '0;
            w_q <= 1'b0;
            neg_q <= 1'b0;
            nega_q <= 1'b0;
            spec_q <= 1'b0;
            spec_res_q <= '0;
            acc_q <= '0;
            x_q <= '0;
            y_q <= '0;
        end else if (kill_i) begin
            busy_q <= 1'b0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q <= '0;
            op_q <= op_i[2:0];
            w_q <= w;
            neg_q <= neg_a ^ neg_b;
            nega_q <= neg_a;
            spec_q <= special_o;
            spec_res_q <= special_res_o;
            acc_q <= '0;
            x_q <= is_div ? mag_a << (w ? XLEN - WORD_W : 0) : mag_b;
            y_q <= {{XLEN{1'b0}}, is_div ? mag_b : mag_a};
        end else if (busy_q) begin
            busy_q <= !done_o;
            cnt_q <= cnt_q + 6'd1;
            acc_q <= acc_d;
            x_q <= x_d;
            y_q <= y_d;
        end
    end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: single-cycle ALU plus iterative multiply/divide behind a valid/ready handshake
module exec_unit import exec_pkg::*; #(
    parameter int XLEN         = 64,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    output logic busy,
    exec_if.slave io
);
    state_e          state_q;
    logic [XLEN-1:0] res_q, ua, ub, sa, sb, alu_r, alu_res, md_res, md_spec_res;
    logic            zero_q, w, eq, is_md, fire, go_calc, md_done, md_spec;
    logic [5:0]      sh;
    assign w = io.work_on_word && XLEN == 64;
    assign ua = w ? XLEN'({32'b0, io.a[31:0]}) : io.a;
    assign ub = w ? XLEN'({32'b0, io.b[31:0]}) : io.b;
    assign sa = w ? XLEN'(sext32(io.a[31:0])) : io.a;
    assign sb = w ? XLEN'(sext32(io.b[31:0])) : io.b;
    assign sh = 6'(io.b) & ((w || XLEN == 32) ? 6'h1f : 6'h3f);
    assign eq = w ? io.a[31:0] == io.b[31:0] : io.a == io.b;
    assign is_md = io.op[4:3] == 2'b10;
    assign fire = io.in_valid && io.in_ready;
    assign go_calc = is_md && !(FAST_SPECIAL && md_spec);
    assign io.in_ready = !flush && (state_q == S_IDLE || (state_q == S_DONE && io.out_ready));
    assign io.out_valid = state_q == S_DONE;
    assign io.res = res_q;
    assign io.zero = zero_q;
    assign busy = state_q == S_CALC;
    always_comb begin
        case (op_e'(io.op))
            OP_ADD:  alu_r = io.a + io.b;
            OP_SUB:  alu_r = io.a - io.b;
            OP_SLL:  alu_r = io.a << sh;
            OP_SLT:  alu_r = XLEN'($signed(sa) < $signed(sb));
            OP_SLTU: alu_r = XLEN'(ua < ub);
            OP_XOR:  alu_r = io.a ^ io.b;
            OP_SRL:  alu_r = ua >> sh;
            OP_SRA:  alu_r = $signed(sa) >>> sh;
            OP_OR:   alu_r = io.a | io.b;
            OP_AND:  alu_r = io.a & io.b;
            default: alu_r = '0;
        endcase
        alu_res = w ? XLEN'(sext32(alu_r[31:0])) : alu_r;
    end
    muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk(clk), .rst(rst), .kill_i(flush), .start_i(fire && go_calc),
        .op_i(op_e'(io.op)), .word_i(io.work_on_word), .a_i(io.a), .b_i(io.b),
        .done_o(md_done), .special_o(md_spec), .res_o(md_res), .special_res_o(md_spec_res)
    );
    // flush beats a same-cycle accept or consume; reset beats everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            res_q <= '0;
            zero_q <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
        end else if (fire) begin
            state_q <= go_calc ? S_CALC : S_DONE;
            res_q <= is_md ? md_spec_res : alu_res;
            zero_q <= eq;
        end else if (state_q == S_CALC && md_done) begin
            state_q <= S_DONE;
            res_q <= md_res;
        end else if (state_q == S_DONE && io.out_ready) begin
            state_q <= S_IDLE;
        end
    end
endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, giving the datapath width (legal values 32, 64).
REQ-002 The module SHALL have parameter FAST_SPECIAL, default 1, which makes divide-by-zero and signed overflow complete in 1 cycle instead of iterating.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port flush, input, 1, which discards any in-flight or held operation.
REQ-006 The module SHALL have port in_valid, input, 1, meaning the operands and op are presented.
REQ-007 The module SHALL have port in_ready, output, 1, meaning an operation can be accepted this cycle.
REQ-008 The module SHALL have ports a and b, input, XLEN each, the operands.
REQ-009 The module SHALL have port op, input, 5, the operation code: 0-9 are ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; 16-23 are MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-010 The module SHALL have port work_on_word, input, 1, selecting 32-bit word operation (XLEN=64 only).
REQ-011 The module SHALL have ports out_valid (output, 1, result present) and out_ready (input, 1, consumer accepts).
REQ-012 The module SHALL have ports res (output, XLEN, the result) and zero (output, 1, registered flag meaning a==b for the accepted operands).
REQ-013 The module SHALL have port busy, output, 1, high while the state is CALC.

Function
REQ-014 The FSM SHALL have states IDLE, CALC and DONE; a transfer occurs on in_valid&&in_ready, and the result is consumed on out_valid&&out_ready.
REQ-015 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1 (back-to-back accept), and 0 otherwise.
REQ-016 For ops 0-9, acceptance SHALL go to DONE with res/zero registered, so out_valid is high in the cycle after the accept (latency 1).
REQ-017 For ops 16-23, acceptance SHALL go to CALC and run a radix-2 iteration of W=XLEN cycles (W=32 if work_on_word), then DONE; out_valid SHALL assert W+1 cycles after the accept.
REQ-018 DONE SHALL return to IDLE on consume unless a new accept occurs in the same cycle.
REQ-019 res and zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 Shift amounts SHALL be taken from b[5:0] for XLEN=64 and from b[4:0] for word ops or XLEN=32; SRA SHALL be arithmetic.
REQ-021 With work_on_word, operands SHALL be taken from [31:0] (sign-extended for signed ops, zero-extended for unsigned ops) and res SHALL be sign-extended from bit 31.
REQ-022 MUL SHALL return the low W bits of the product; MULH, MULHSU and MULHU SHALL return the high W bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-023 For divide by zero, DIV/DIVU SHALL return all ones and REM/REMU SHALL return the dividend.
REQ-024 For signed overflow (most-negative ÷ −1), DIV SHALL return the dividend and REM SHALL return 0.
REQ-025 Signed division SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-026 When FAST_SPECIAL=1, the REQ-023 and REQ-024 cases SHALL skip CALC with latency 1.
REQ-027 flush SHALL force IDLE and out_valid=0 next cycle, overriding a same-cycle accept or consume; in_ready SHALL be 0 while flush=1.
REQ-028 Undefined op codes SHALL be accepted with latency 1 and SHALL produce res=0.

Reset
REQ-029 On rst the state SHALL become IDLE, and out_valid, busy, res, zero and all iteration counters and registers SHALL become 0; in_ready SHALL be 1 in the cycle after reset.
REQ-030 rst SHALL override flush and in_valid, including mid-CALC, after which no stale result SHALL appear.

Structure
REQ-031 The op encodings, FSM state encodings and XLEN-independent constants SHALL live in shared package exec_pkg, an extension of the existing ALU op include.
REQ-032 The iterative multiply/divide SHALL be sub-module muldiv_iter, with start/done handshake, signed-fixup logic and special-case detection.
REQ-033 Single-cycle ALU ops SHALL be computed combinationally and registered in exec_unit.

Verification
REQ-034 Bench: ADD a=5, b=−3 (XLEN=64) -> out_valid 1 cycle later, res=2, zero=0; then back-to-back SUB a=b=7 accepted while consuming -> res=0, zero=1.
REQ-035 Bench: MULH a=0x8000_0000_0000_0000, b=2 -> res=0xFFFF_FFFF_FFFF_FFFF, out_valid 65 cycles after accept.
REQ-036 Bench: DIV a=−7, b=2 -> res=−3; REM -> res=−1; word DIVW a=0x1_8000_0000, b=−1 -> res=0xFFFF_FFFF_8000_0000 (overflow).
REQ-037 Bench: DIVU b=0, a=9 -> res=all ones, latency 1 (FAST_SPECIAL=1); REMU -> res=9.
REQ-038 Bench: flush at CALC cycle 10 of a DIV -> out_valid never asserts, in_ready=1 next cycle; rst mid-CALC -> all outputs 0.
REQ-039 Bench: hold out_ready=0 for 5 cycles on a result -> res/zero stable, in_ready=0, no new accept.
